ram_16x8: RTL and testbench
===========================

RAM_16X8 -- requirements
Module: ram_16x8

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on rising edge.
REQ-002 SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-003 SHALL have port ADDR, input, 4, word address driven by the MAR.
REQ-004 SHALL have port BUS_IN, input, 8, data from the shared bus for run-mode writes.
REQ-005 SHALL have port BUS_OUT, output, 8, registered read data toward the bus mux.
REQ-006 SHALL have port OE, input, 1, read enable.
REQ-007 SHALL have port WE, input, 1, run-mode write enable.
REQ-008 SHALL have port PRGM, input, 1, program-mode write strobe.
REQ-009 SHALL have port PRGM_IN, input, 8, manual programming data.
REQ-010 SHALL have port HLT, input, 1, computer halt; blocks WE writes only.
REQ-011 SHALL have port BOOT_GO, input, 1, one-cycle start of EEPROM image load.
REQ-012 SHALL have ports BOOT_DATA (input, 8) and BOOT_VALID (input, 1), byte stream from the EEPROM reader.
REQ-013 SHALL have port BOOT_READY, output, 1, asserted while a boot byte is accepted.
REQ-014 SHALL have ports BUSY (output, 1, boot or clear in progress) and BOOT_DONE (output, 1, sticky load-complete flag).

Function
REQ-015 SHALL store 16 words of 8 bits in registers.
REQ-016 SHALL implement FSM states IDLE, BOOT, CLEAR; BUSY = 1 in BOOT and CLEAR only.
REQ-017 SHALL update BUS_OUT every cycle: OE=1 -> mem[ADDR] of the previous contents; OE=0 -> 8'h00; latency 1 cycle.
REQ-018 SHALL return old data on read and write to the same address in the same cycle.
REQ-019 In IDLE, PRGM=1 SHALL write PRGM_IN to mem[ADDR].
REQ-020 In IDLE, WE=1 with PRGM=0 and HLT=0 SHALL write BUS_IN to mem[ADDR].
REQ-021 PRGM SHALL take priority over WE when both are high; HLT=1 SHALL suppress WE writes but not PRGM writes or reads.
REQ-022 In IDLE, BOOT_GO=1 SHALL move to BOOT, clear the 4-bit pointer to 0, and clear BOOT_DONE.
REQ-023 In BOOT, BOOT_READY SHALL be 1; each cycle with BOOT_VALID=1 SHALL write BOOT_DATA to mem[pointer] and increment the pointer.
REQ-024 The accepted byte at pointer 15 SHALL end the load: the FSM returns to IDLE, BOOT_READY drops to 0 on the next cycle, and BOOT_DONE is set to 1.
REQ-025 In BOOT, BOOT_VALID=0 SHALL stall without a write; the pointer SHALL NOT wrap past 15.
REQ-026 In BOOT and CLEAR, WE, PRGM and BOOT_GO SHALL be ignored; reads per REQ-017 SHALL continue.
REQ-027 BOOT_DONE SHALL remain 1 until the next accepted BOOT_GO or RESET.

Reset
REQ-028 With RESET=1 at a clock edge, the block SHALL set BUS_OUT=0, BOOT_READY=0, BOOT_DONE=0 and pointer=0, and SHALL enter IDLE or CLEAR per REQ-030.
REQ-029 RESET SHALL abort an in-progress BOOT or CLEAR; writes already done SHALL be retained; no write SHALL occur in the reset cycle.

Configuration
REQ-030 With RAM_CLEAR_ON_RESET_EN defined, the cycle after RESET deasserts SHALL enter CLEAR, write 8'h00 to addresses 0..15 over 16 cycles (BUSY=1), then go to IDLE.
REQ-031 Without RAM_CLEAR_ON_RESET_EN, reset SHALL go directly to IDLE, BUSY SHALL stay 0 after reset, and memory contents SHALL be unchanged by reset.

Verification
REQ-032 Test: ADDR=4, PRGM=1, PRGM_IN=8'h50 for 1 cycle, then OE=1 -> BUS_OUT=8'h50 one cycle after OE.
REQ-033 Test: ADDR=4, PRGM=1 with PRGM_IN=8'hA0, WE=1 with BUS_IN=8'h33 in the same cycle -> mem[4]=8'hA0; then HLT=1, WE=1, BUS_IN=8'h77 -> mem[4] still 8'hA0.
REQ-034 Test: BOOT_GO pulse, then 16 bytes 8'h10..8'h1F with BOOT_VALID gapped every other cycle -> mem[i]=8'h10+i, BOOT_DONE=1, BUSY=0, BOOT_READY=0.
REQ-035 Test: RESET after 5 boot bytes -> IDLE, BOOT_DONE=0, mem[0..4] loaded, mem[5..15] unchanged (macro off).
REQ-036 Test: macro on, RESET after nonzero contents -> BUSY=1 for exactly 16 cycles, then all 16 words read 8'h00.
REQ-037 Test: OE=0 during writes -> BUS_OUT=8'h00 throughout.

Source files
------------

// File: rtl/ram_16x8.sv
// ram_16x8: 16 x 8 register-file RAM with manual programming, run-mode
// bus writes, EEPROM boot-image loader and optional clear-after-reset.
//
// Optional feature macro: RAM_CLEAR_ON_RESET_EN
//   defined   -> after reset the FSM walks addresses 0..15 writing 8'h00
//   undefined -> reset lands directly in IDLE and memory is left untouched
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | normal operation: PRGM / WE writes, BOOT_GO starts a load
// BOOT  | accepting BOOT_DATA into mem[ptr] on each BOOT_VALID cycle
// CLEAR | writing 8'h00 into mem[ptr], one address per cycle

module ram_16x8 (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] ADDR,
    input  logic [7:0] BUS_IN,
    output logic [7:0] BUS_OUT,
    input  logic       OE,
    input  logic       WE,
    input  logic       PRGM,
    input  logic [7:0] PRGM_IN,
    input  logic       HLT,
    input  logic       BOOT_GO,
    input  logic [7:0] BOOT_DATA,
    input  logic       BOOT_VALID,
    output logic       BOOT_READY,
    output logic       BUSY,
    output logic       BOOT_DONE
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BOOT  = 2'd1,
        CLEAR = 2'd2
    } state_t;

`ifdef RAM_CLEAR_ON_RESET_EN
    localparam state_t RESET_STATE = CLEAR;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t     state;
    state_t     next_state;
    logic [7:0] mem [16];
    logic [3:0] ptr;

    logic       mem_we;
    logic [3:0] mem_waddr;
    logic [7:0] mem_wdata;
    logic       ptr_clr;
    logic       ptr_inc;
    logic       done_set;
    logic       done_clr;

    assign BOOT_READY = (state == BOOT);
    assign BUSY       = (state != IDLE);

    // State register; reset either parks in IDLE or starts the clear sweep.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= RESET_STATE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the single memory write port selection.
    always_comb begin
        next_state = state;
        mem_we     = 1'b0;
        mem_waddr  = ADDR;
        mem_wdata  = PRGM_IN;
        ptr_clr    = 1'b0;
        ptr_inc    = 1'b0;
        done_set   = 1'b0;
        done_clr   = 1'b0;
        unique case (state)
            IDLE: begin
                if (PRGM) begin
                    mem_we    = 1'b1;
                    mem_wdata = PRGM_IN;
                end else if (WE && !HLT) begin
                    mem_we    = 1'b1;
                    mem_wdata = BUS_IN;
                end
                if (BOOT_GO) begin
                    next_state = BOOT;
                    ptr_clr    = 1'b1;
                    done_clr   = 1'b1;
                end
            end
            BOOT: begin
                if (BOOT_VALID) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr;
                    mem_wdata = BOOT_DATA;
                    // The pointer parks at 15 rather than wrapping.
                    if (ptr == 4'd15) begin
                        next_state = IDLE;
                        done_set   = 1'b1;
                    end else begin
                        ptr_inc = 1'b1;
                    end
                end
            end
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = ptr;
                mem_wdata = 8'h00;
                if (ptr == 4'd15) begin
                    next_state = IDLE;
                end else begin
                    ptr_inc = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Shared address pointer for boot loading and clearing.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr <= 4'd0;
        end else if (ptr_clr) begin
            ptr <= 4'd0;
        end else if (ptr_inc) begin
            ptr <= ptr + 4'd1;
        end
    end

    // Sticky load-complete flag, cleared only by an accepted BOOT_GO or reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BOOT_DONE <= 1'b0;
        end else if (done_clr) begin
            BOOT_DONE <= 1'b0;
        end else if (done_set) begin
            BOOT_DONE <= 1'b1;
        end
    end

    // Registered read port; sees pre-write contents, so read-during-write
    // to the same address returns the old word.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            BUS_OUT <= 8'h00;
        end else begin
            BUS_OUT <= OE ? mem[ADDR] : 8'h00;
        end
    end

    // Storage array; contents survive reset and no write lands in a reset cycle.
    always_ff @(posedge CLK) begin
        if (!RESET && mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_ram_16x8.sv
// tb_ram_16x8: self-checking bench for ram_16x8 with a reference memory
// model and a queue of expected read data.
// Works with or without RAM_CLEAR_ON_RESET_EN defined.

module tb_ram_16x8;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [3:0] ADDR;
    logic [7:0] BUS_IN;
    logic [7:0] BUS_OUT;
    logic       OE;
    logic       WE;
    logic       PRGM;
    logic [7:0] PRGM_IN;
    logic       HLT;
    logic       BOOT_GO;
    logic [7:0] BOOT_DATA;
    logic       BOOT_VALID;
    logic       BOOT_READY;
    logic       BUSY;
    logic       BOOT_DONE;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] model [16];
    logic [7:0] exp_q [$];
    logic [7:0] exp;

    ram_16x8 dut (
        .CLK(CLK), .RESET(RESET), .ADDR(ADDR), .BUS_IN(BUS_IN), .BUS_OUT(BUS_OUT),
        .OE(OE), .WE(WE), .PRGM(PRGM), .PRGM_IN(PRGM_IN), .HLT(HLT),
        .BOOT_GO(BOOT_GO), .BOOT_DATA(BOOT_DATA), .BOOT_VALID(BOOT_VALID),
        .BOOT_READY(BOOT_READY), .BUSY(BUSY), .BOOT_DONE(BOOT_DONE)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        OE = 0; WE = 0; PRGM = 0; HLT = 0; BOOT_GO = 0; BOOT_VALID = 0;
        BUS_IN = 8'h00; PRGM_IN = 8'h00; BOOT_DATA = 8'h00; ADDR = 4'd0;
    endtask

    task automatic test_reset;
        int n;
        idle_inputs();
        RESET = 1;
        tick();
        tick();
        checks++;
        if (BUS_OUT !== 8'h00) begin errors++; $display("FAIL reset_bus_out: got %h want 00", BUS_OUT); end
        checks++;
        if (BOOT_READY !== 1'b0) begin errors++; $display("FAIL reset_boot_ready: got %b want 0", BOOT_READY); end
        checks++;
        if (BOOT_DONE !== 1'b0) begin errors++; $display("FAIL reset_boot_done: got %b want 0", BOOT_DONE); end
        RESET = 0;
`ifdef RAM_CLEAR_ON_RESET_EN
        n = 0;
        while (BUSY === 1'b1 && n < 40) begin tick(); n++; end
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_clear_end: busy=%b after %0d cycles want 0", BUSY, n); end
`else
        n = 0;
        tick();
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", BUSY); end
`endif
        // Give every word a known value for later checks.
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i); PRGM = 1; PRGM_IN = 8'hC0 + 8'(i);
            tick();
            model[i] = 8'hC0 + 8'(i);
        end
        PRGM = 0;
    endtask

    task automatic test_prgm_read;
        idle_inputs();
        ADDR = 4'd4; PRGM = 1; PRGM_IN = 8'h50;
        tick();
        model[4] = 8'h50;
        checks++;
        if (BUS_OUT !== 8'h00) begin errors++; $display("FAIL prgm_oe_low: got %h want 00", BUS_OUT); end
        PRGM = 0; OE = 1;
        exp_q.push_back(model[4]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL prgm_read: got %h want %h", BUS_OUT, exp); end
        OE = 0;
        tick();
        checks++;
        if (BUS_OUT !== 8'h00) begin errors++; $display("FAIL oe_drop: got %h want 00", BUS_OUT); end
    endtask

    task automatic test_priority_hlt;
        idle_inputs();
        ADDR = 4'd4; PRGM = 1; PRGM_IN = 8'hA0; WE = 1; BUS_IN = 8'h33;
        tick();
        model[4] = 8'hA0;
        PRGM = 0; HLT = 1; WE = 1; BUS_IN = 8'h77;
        tick();
        WE = 0; OE = 1;
        exp_q.push_back(model[4]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL prio_hlt_word: got %h want %h", BUS_OUT, exp); end
        // HLT blocks neither PRGM nor the read that happens alongside it.
        PRGM = 1; PRGM_IN = 8'h5A; OE = 1;
        exp_q.push_back(model[4]);
        tick();
        model[4] = 8'h5A;
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL hlt_read_old: got %h want %h", BUS_OUT, exp); end
        PRGM = 0;
        exp_q.push_back(model[4]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL hlt_prgm_write: got %h want %h", BUS_OUT, exp); end
        HLT = 0; OE = 0; ADDR = 4'd2; WE = 1; BUS_IN = 8'h99;
        tick();
        model[2] = 8'h99;
        WE = 0; OE = 1;
        exp_q.push_back(model[2]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL we_write: got %h want %h", BUS_OUT, exp); end
        OE = 0;
    endtask

    task automatic test_read_during_write;
        idle_inputs();
        ADDR = 4'd7; OE = 1; PRGM = 1; PRGM_IN = 8'h3C;
        exp_q.push_back(model[7]);
        tick();
        model[7] = 8'h3C;
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL rdw_old: got %h want %h", BUS_OUT, exp); end
        PRGM = 0;
        exp_q.push_back(model[7]);
        tick();
        exp = exp_q.pop_front();
        checks++;
        if (BUS_OUT !== exp) begin errors++; $display("FAIL rdw_new: got %h want %h", BUS_OUT, exp); end
        OE = 0;
    endtask

    task automatic test_oe_low;
        idle_inputs();
        for (int i = 0; i < 6; i++) begin
            ADDR = 4'(i + 8);
            if (i % 2 == 0) begin PRGM = 1; PRGM_IN = 8'h60 + 8'(i); WE = 0; end
            else begin PRGM = 0; WE = 1; BUS_IN = 8'h60 + 8'(i); end
            tick();
            model[i + 8] = 8'h60 + 8'(i);
            checks++;
            if (BUS_OUT !== 8'h00) begin errors++; $display("FAIL oe_low_%0d: got %h want 00", i, BUS_OUT); end
        end
        idle_inputs();
        for (int i = 8; i < 14; i++) begin
            ADDR = 4'(i); OE = 1;
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (BUS_OUT !== exp) begin errors++; $display("FAIL oe_low_rd%0d: got %h want %h", i, BUS_OUT, exp); end
        end
        OE = 0;
    endtask

    task automatic test_boot;
        int b;
        int cyc;
        idle_inputs();
        BOOT_GO = 1;
        tick();
        BOOT_GO = 0;
        checks++;
        if (BUSY !== 1'b1 || BOOT_READY !== 1'b1 || BOOT_DONE !== 1'b0) begin
            errors++; $display("FAIL boot_start: busy=%b ready=%b done=%b want 1 1 0", BUSY, BOOT_READY, BOOT_DONE);
        end
        b = 0; cyc = 0;
        while (b < 16 && cyc < 100) begin
            if (cyc % 2 == 1) begin
                BOOT_VALID = 1; BOOT_DATA = 8'h10 + 8'(b);
                WE = 0; PRGM = 0; BOOT_GO = 0;
                checks++;
                if (BOOT_READY !== 1'b1) begin errors++; $display("FAIL boot_ready_%0d: got %b want 1", b, BOOT_READY); end
            end else begin
                // Gap cycle: disruptive inputs that BOOT must ignore.
                BOOT_VALID = 0; BOOT_DATA = 8'hFF;
                ADDR = 4'(b); WE = 1; BUS_IN = 8'hEE; PRGM = 1; PRGM_IN = 8'hDD; BOOT_GO = 1;
            end
            tick();
            if (BOOT_VALID) begin model[b] = 8'h10 + 8'(b); b++; end
            cyc++;
        end
        idle_inputs();
        checks++;
        if (b != 16) begin errors++; $display("FAIL boot_timeout: got %0d bytes want 16", b); end
        checks++;
        if (BOOT_DONE !== 1'b1 || BUSY !== 1'b0 || BOOT_READY !== 1'b0) begin
            errors++; $display("FAIL boot_end: done=%b busy=%b ready=%b want 1 0 0", BOOT_DONE, BUSY, BOOT_READY);
        end
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i); OE = 1;
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (BUS_OUT !== exp) begin errors++; $display("FAIL boot_mem%0d: got %h want %h", i, BUS_OUT, exp); end
        end
        OE = 0;
        tick(); tick();
        checks++;
        if (BOOT_DONE !== 1'b1) begin errors++; $display("FAIL boot_done_sticky: got %b want 1", BOOT_DONE); end
    endtask

    task automatic test_reset_abort;
        int n;
        idle_inputs();
        BOOT_GO = 1;
        tick();
        BOOT_GO = 0;
        checks++;
        if (BOOT_DONE !== 1'b0) begin errors++; $display("FAIL abort_done_clr: got %b want 0", BOOT_DONE); end
        for (int i = 0; i < 5; i++) begin
            BOOT_VALID = 1; BOOT_DATA = 8'h20 + 8'(i);
            tick();
            model[i] = 8'h20 + 8'(i);
        end
        // No write may land in the reset cycle.
        BOOT_VALID = 1; BOOT_DATA = 8'hAB; RESET = 1;
        tick();
        RESET = 0; BOOT_VALID = 0;
        checks++;
        if (BOOT_DONE !== 1'b0 || BOOT_READY !== 1'b0) begin
            errors++; $display("FAIL abort_flags: done=%b ready=%b want 0 0", BOOT_DONE, BOOT_READY);
        end
`ifdef RAM_CLEAR_ON_RESET_EN
        n = 0;
        while (BUSY === 1'b1 && n < 40) begin tick(); n++; end
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
`else
        n = 0;
`endif
        checks++;
        if (BUSY !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b want 0 (waited %0d)", BUSY, n); end
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i); OE = 1;
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (BUS_OUT !== exp) begin errors++; $display("FAIL abort_mem%0d: got %h want %h", i, BUS_OUT, exp); end
        end
        OE = 0;
    endtask

`ifdef RAM_CLEAR_ON_RESET_EN
    task automatic test_clear_on_reset;
        int busy_cycles;
        int n;
        idle_inputs();
        for (int i = 0; i < 16; i++) begin
            ADDR = 4'(i); PRGM = 1; PRGM_IN = 8'h80 + 8'(i);
            tick();
        end
        PRGM = 0;
        RESET = 1;
        tick();
        RESET = 0;
        busy_cycles = (BUSY === 1'b1) ? 1 : 0;
        n = 0;
        while (BUSY === 1'b1 && n < 40) begin
            tick();
            n++;
            if (BUSY === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 16) begin errors++; $display("FAIL clear_busy_len: got %0d want 16", busy_cycles); end
        for (int i = 0; i < 16; i++) begin
            model[i] = 8'h00;
            ADDR = 4'(i); OE = 1;
            exp_q.push_back(model[i]);
            tick();
            exp = exp_q.pop_front();
            checks++;
            if (BUS_OUT !== exp) begin errors++; $display("FAIL clear_mem%0d: got %h want %h", i, BUS_OUT, exp); end
        end
        OE = 0;
    endtask
`endif

    initial begin
        RESET = 1;
        idle_inputs();
        test_reset();
        test_prgm_read();
        test_priority_hlt();
        test_read_during_write();
        test_oe_low();
        test_boot();
        test_reset_abort();
`ifdef RAM_CLEAR_ON_RESET_EN
        test_clear_on_reset();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
